// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- 8-requester round-robin arbiter with a per-ownership hold limit.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   req[7:0]     per-requester request, bit i = requester i
//   lock         (only with RR_ARB_LOCK_EN) suppresses hold-limit expiry while
//                the owner keeps requesting
//   grant[7:0]   registered one-hot grant, all-zero when idle
//   grant_id     registered binary index of the owner, meaningful when grant_valid=1
//   grant_valid  registered, high while a grant is held
//   expire       registered one-cycle pulse, high together with the first cycle
//                of a grant that was forced by the hold limit
//
// Parameter MAX_HOLD (1..255): maximum consecutive grant cycles per ownership.
// Optional feature macro: RR_ARB_LOCK_EN (adds the lock input).

module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
`ifdef RR_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       expire
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state, w_state_n;
  logic [2:0] r_ptr, w_ptr_n;
  logic [2:0] r_id, w_id_n;
  logic [7:0] r_hold, w_hold_n;
  logic [7:0] r_grant;
  logic       r_valid, w_valid_n;
  logic       r_expire, w_expire_n;

  logic       w_lock;
  logic [7:0] w_owner_bit;
  logic       w_owner_req;
  logic       w_at_limit;
  logic [7:0] w_cand;
  logic [2:0] w_idx;
  logic [2:0] w_sel_id;
  logic       w_found;

`ifdef RR_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_owner_bit = 8'h01 << r_id;
  assign w_owner_req = |(req & w_owner_bit);
  assign w_at_limit  = (r_hold == HOLD_LAST);

  // Candidate set: on an expiry the current owner is excluded so the scan
  // (which starts at owner+1) lands on the next distinct requester.
  always_comb begin
    w_cand = req;
    if (r_state == S_GRANT && w_owner_req && w_at_limit && !w_lock)
      w_cand = req & ~w_owner_bit;
  end

  // Rotating priority scan: ptr, ptr+1, ... wrapping modulo 8.
  always_comb begin
    w_found  = 1'b0;
    w_sel_id = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_idx = r_ptr + 3'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_sel_id = w_idx;
      end
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_ptr_n    = r_ptr;
    w_id_n     = r_id;
    w_hold_n   = r_hold;
    w_valid_n  = r_valid;
    w_expire_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n = S_GRANT;
          w_id_n    = w_sel_id;
          w_hold_n  = '0;
          w_ptr_n   = w_sel_id + 3'd1;
          w_valid_n = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_owner_req) begin
          if (!w_at_limit) begin
            w_hold_n = r_hold + 8'd1;
          end else if (w_lock) begin
            w_hold_n = r_hold;
          end else if (w_found) begin
            w_id_n     = w_sel_id;
            w_hold_n   = '0;
            w_ptr_n    = w_sel_id + 3'd1;
            w_expire_n = 1'b1;
          end else begin
            w_hold_n = '0;
            w_ptr_n  = r_id + 3'd1;
          end
        end else if (w_found) begin
          w_id_n   = w_sel_id;
          w_hold_n = '0;
          w_ptr_n  = w_sel_id + 3'd1;
        end else begin
          w_state_n = S_IDLE;
          w_valid_n = 1'b0;
          w_hold_n  = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_id     <= '0;
      r_hold   <= '0;
      r_valid  <= 1'b0;
      r_expire <= 1'b0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_ptr    <= w_ptr_n;
      r_id     <= w_id_n;
      r_hold   <= w_hold_n;
      r_valid  <= w_valid_n;
      r_expire <= w_expire_n;
      r_grant  <= w_valid_n ? (8'h01 << w_id_n) : '0;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_id;
  assign grant_valid = r_valid;
  assign expire      = r_expire;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  typedef struct {
    int unsigned cyc;
    bit          dut;
    bit [2:0]    id;
    bit          v;
    bit          e;
    bit          chk_id;
    string       name;
  } exp_t;

  exp_t q[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_a, req_b;
  logic [7:0] grant_a, grant_b;
  logic [2:0] id_a, id_b;
  logic       valid_a, valid_b, exp_a, exp_b;

  int unsigned cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a),
    .grant(grant_a), .grant_id(id_a), .grant_valid(valid_a), .expire(exp_a)
  );

  rr_arbiter8 #(.MAX_HOLD(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b),
    .grant(grant_b), .grant_id(id_b), .grant_valid(valid_b), .expire(exp_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input int act, input int req_v);
    n_chk++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h (cycle %0d)", nm, fld, act, req_v, cyc);
    end
  endtask

  // Monitor: compares every expectation whose target cycle has arrived.
  exp_t       x;
  logic [7:0] g, eg;
  logic [2:0] gi;
  logic       gv, ge;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x  = q.pop_front();
      g  = x.dut ? grant_b : grant_a;
      gi = x.dut ? id_b    : id_a;
      gv = x.dut ? valid_b : valid_a;
      ge = x.dut ? exp_b   : exp_a;
      eg = x.v ? (8'h01 << x.id) : 8'h00;
      chk(x.name, "grant", int'(g), int'(eg));
      chk(x.name, "grant_valid", int'(gv), int'(x.v));
      chk(x.name, "expire", int'(ge), int'(x.e));
      if (x.chk_id) chk(x.name, "grant_id", int'(gi), int'(x.id));
      chk(x.name, "onehot", int'($countones(g) <= 1), 1);
    end
  end

  // Drive req on one DUT and queue what that DUT must show after the next edge.
  task automatic st(input bit d, input logic [7:0] r, input int id, input bit v,
                    input bit e, input string nm, input bit ci = 1'b0);
    if (d) req_b = r; else req_a = r;
    q.push_back('{cyc + 1, d, 3'(id), v, e, v | ci, nm});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    st(0, 8'h00, 0, 0, 0, "rst_a", 1);
    req_a = 8'hFF;
    st(1, 8'h00, 0, 0, 0, "rst_b_req_ignored", 1);
    rst = 1'b0;

    // Two-requester release hand-off, no idle bubble
    st(0, 8'h81, 0, 1, 0, "r81_first");
    st(0, 8'h80, 7, 1, 0, "release_to_7");
    st(0, 8'h00, 0, 0, 0, "to_idle");

    // MAX_HOLD=4 rotation between requesters 1 and 2 (ptr=0 after owner 7)
    for (int i = 0; i < 4; i++) st(0, 8'h06, 1, 1, 0, "hold_1");
    st(0, 8'h06, 2, 1, 1, "expire_to_2");
    for (int i = 0; i < 3; i++) st(0, 8'h06, 2, 1, 0, "hold_2");
    st(0, 8'h06, 1, 1, 1, "expire_to_1");
    st(0, 8'h00, 0, 0, 0, "idle_again");

    // Lone requester: re-grant without expire
    for (int i = 0; i < 10; i++) st(0, 8'h10, 4, 1, 0, "lone_4");

    // Owner 3, then reset mid-ownership
    st(0, 8'h08, 3, 1, 0, "release_to_3");
    st(0, 8'h08, 3, 1, 0, "hold_3");
    rst = 1'b1;
    st(0, 8'h08, 0, 0, 0, "rst_mid", 1);
    rst = 1'b0;
    st(0, 8'h88, 3, 1, 0, "post_rst_ptr0");
    for (int i = 0; i < 3; i++) st(0, 8'h88, 3, 1, 0, "no_preempt_3");
    st(0, 8'h88, 7, 1, 1, "expire_to_7");
    st(0, 8'h00, 0, 0, 0, "final_idle_a");

    // MAX_HOLD=1: rotate every cycle with wrap
    st(1, 8'hFF, 0, 1, 0, "ff_id0");
    for (int i = 1; i <= 8; i++) st(1, 8'hFF, i % 8, 1, 1, "ff_rotate");
    st(1, 8'h00, 0, 0, 0, "final_idle_b");

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
